// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stop levels, stall vectors,
// FSM state encodings and stage indices.
package pipe_ctrl_pkg;

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Bit 5 is the wb stage, bit 0 the pc.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_LU   = 6'b000111;
  localparam logic [5:0] STALL_MC   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MC_BUSY  = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  localparam int STG_PC      = 0;
  localparam int STG_IF_ID   = 1;
  localparam int STG_ID_EXE  = 2;
  localparam int STG_EXE_MEM = 3;
  localparam int STG_MEM_WB  = 4;
  localparam int STG_WB      = 5;

  function automatic logic any_stop(input logic [5:0] vec);
    return |vec;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Load-use hazard comparator: flags an ID-stage read of a register that the
// load currently in EX has not yet produced.
module pipe_ctrl_hazard #(
  parameter int RADDR_WIDTH = 5
) (
  input  logic [RADDR_WIDTH-1:0] id_rs1,
  input  logic [RADDR_WIDTH-1:0] id_rs2,
  input  logic                   id_rs1_re,
  input  logic                   id_rs2_re,
  input  logic                   ex_is_load,
  input  logic [RADDR_WIDTH-1:0] ex_rd,
  output logic                   load_use
);

  logic rs1_hit_s;
  logic rs2_hit_s;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign rs1_hit_s = id_rs1_re & (id_rs1 == ex_rd);
  assign rs2_hit_s = id_rs2_re & (id_rs2 == ex_rd);
  assign load_use  = ex_is_load & (ex_rd != {RADDR_WIDTH{1'b0}}) & (rs1_hit_s | rs2_hit_s);

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: per-stage stall vector, branch flush, bus
// timeout error and stall-cycle counter for the 5-stage core.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RADDR_WIDTH-1:0] id_rs1_i,
  input  logic [RADDR_WIDTH-1:0] id_rs2_i,
  input  logic                   id_rs1_re_i,
  input  logic                   id_rs2_re_i,
  input  logic                   ex_inst_is_load_i,
  input  logic [RADDR_WIDTH-1:0] ex_rd_i,
  input  logic                   ex_mc_start_i,
  input  logic                   ex_mc_done_i,
  input  logic                   mem_req_i,
  input  logic                   mem_ack_i,
  input  logic                   jump_i,
  input  logic [ADDR_WIDTH-1:0]  jump_addr_i,
  output logic [5:0]             stall_o,
  output logic                   flush_o,
  output logic [ADDR_WIDTH-1:0]  flush_addr_o,
  output logic                   bus_err_o,
  output logic [CNT_WIDTH-1:0]   stall_cnt_o
);

  localparam int WCW = $clog2(MEM_TIMEOUT) + 1;

  logic [1:0]           state_r, state_nxt_s, ret_state_s;
  logic                 pend_mc_r, pend_nxt_s;
  logic                 mc_done_r, done_nxt_s;
  logic [WCW-1:0]       wait_cnt_r, wcnt_nxt_s;
  logic                 bus_err_r, err_nxt_s;
  logic [CNT_WIDTH-1:0] stall_cnt_r;
  logic [5:0]           stall_pre_s;
  logic                 load_use_s, mem_wait_s, timeout_s, flush_s;

  pipe_ctrl_hazard #(.RADDR_WIDTH(RADDR_WIDTH)) u_hazard (
    .id_rs1     (id_rs1_i),
    .id_rs2     (id_rs2_i),
    .id_rs1_re  (id_rs1_re_i),
    .id_rs2_re  (id_rs2_re_i),
    .ex_is_load (ex_inst_is_load_i),
    .ex_rd      (ex_rd_i),
    .load_use   (load_use_s)
  );

  assign mem_wait_s  = mem_req_i & ~mem_ack_i;
  // The wait counter already includes the entry cycle, so this is the last stalled cycle.
  assign timeout_s   = (wait_cnt_r == WCW'(MEM_TIMEOUT - 1));
  assign ret_state_s = (pend_mc_r & ~mc_done_r & ~ex_mc_done_i) ? ST_MC_BUSY : ST_IDLE;

  // FSM next state, raw stall vector and bookkeeping for nested MC/MEM stalls.
  always_comb begin
    stall_pre_s = STALL_NONE;
    state_nxt_s = state_r;
    pend_nxt_s  = pend_mc_r;
    done_nxt_s  = mc_done_r;
    wcnt_nxt_s  = wait_cnt_r;
    err_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_wait_s) begin
          stall_pre_s = STALL_MEM;
          state_nxt_s = ST_MEM_WAIT;
          pend_nxt_s  = ex_mc_start_i;
          done_nxt_s  = 1'b0;
          wcnt_nxt_s  = WCW'(1);
        end else if (ex_mc_start_i) begin
          stall_pre_s = STALL_MC;
          state_nxt_s = ST_MC_BUSY;
          pend_nxt_s  = 1'b0;
          done_nxt_s  = 1'b0;
          wcnt_nxt_s  = {WCW{1'b0}};
        end else if (load_use_s) begin
          stall_pre_s = STALL_LU;
        end else begin
          stall_pre_s = STALL_NONE;
        end
      end
      ST_MC_BUSY: begin
        if (mem_wait_s) begin
          stall_pre_s = STALL_MEM;
          state_nxt_s = ST_MEM_WAIT;
          pend_nxt_s  = 1'b1;
          done_nxt_s  = ex_mc_done_i;
          wcnt_nxt_s  = WCW'(1);
        end else if (ex_mc_done_i) begin
          stall_pre_s = STALL_NONE;
          state_nxt_s = ST_IDLE;
        end else begin
          stall_pre_s = STALL_MC;
        end
      end
      ST_MEM_WAIT: begin
        done_nxt_s = mc_done_r | ex_mc_done_i;
        if (mem_ack_i) begin
          stall_pre_s = STALL_NONE;
          state_nxt_s = ret_state_s;
          pend_nxt_s  = 1'b0;
          done_nxt_s  = 1'b0;
          wcnt_nxt_s  = {WCW{1'b0}};
        end else if (timeout_s) begin
          stall_pre_s = STALL_MEM;
          state_nxt_s = ret_state_s;
          pend_nxt_s  = 1'b0;
          done_nxt_s  = 1'b0;
          wcnt_nxt_s  = {WCW{1'b0}};
          err_nxt_s   = 1'b1;
        end else begin
          stall_pre_s = STALL_MEM;
          wcnt_nxt_s  = wait_cnt_r + WCW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        pend_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        wcnt_nxt_s  = {WCW{1'b0}};
      end
    endcase
  end

  // Output stage: a jump only resolves while EX moves, and it discards the ID instruction.
  always_comb begin
    flush_s = jump_i & (stall_pre_s[STG_EXE_MEM] == NOSTOP);
    if (!rst_i) begin
      stall_o      = STALL_NONE;
      flush_o      = 1'b0;
      flush_addr_o = {ADDR_WIDTH{1'b0}};
    end else if (flush_s) begin
      stall_o      = STALL_NONE;
      flush_o      = 1'b1;
      flush_addr_o = jump_addr_i;
    end else begin
      stall_o      = stall_pre_s;
      flush_o      = 1'b0;
      flush_addr_o = {ADDR_WIDTH{1'b0}};
    end
  end

  // State, wait counter, error pulse and saturating stall counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r     <= ST_IDLE;
      pend_mc_r   <= 1'b0;
      mc_done_r   <= 1'b0;
      wait_cnt_r  <= {WCW{1'b0}};
      bus_err_r   <= 1'b0;
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      pend_mc_r  <= pend_nxt_s;
      mc_done_r  <= done_nxt_s;
      wait_cnt_r <= wcnt_nxt_s;
      bus_err_r  <= err_nxt_s;
      if (any_stop(stall_o) && (stall_cnt_r != {CNT_WIDTH{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus_err_o   = bus_err_r;
  assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed cycles push hand-computed
// expectations; a negedge monitor pops and compares every cycle.
module tb_pipe_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i;
  logic        id_rs1_re_i, id_rs2_re_i, ex_inst_is_load_i;
  logic        ex_mc_start_i, ex_mc_done_i, mem_req_i, mem_ack_i, jump_i;
  logic [31:0] jump_addr_i;
  logic [5:0]  stall_o;
  logic        flush_o, bus_err_o;
  logic [31:0] flush_addr_o, stall_cnt_o;

  typedef struct packed {
    logic [63:0] name;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] addr;
    logic        bus_err;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;

  localparam logic [5:0] S0   = 6'b000000;
  localparam logic [5:0] SLU  = 6'b000111;
  localparam logic [5:0] SMC  = 6'b001111;
  localparam logic [5:0] SMEM = 6'b011111;

  pipe_ctrl #(.ADDR_WIDTH(32), .RADDR_WIDTH(5), .MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
    .ex_inst_is_load_i(ex_inst_is_load_i), .ex_rd_i(ex_rd_i),
    .ex_mc_start_i(ex_mc_start_i), .ex_mc_done_i(ex_mc_done_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i),
    .stall_o(stall_o), .flush_o(flush_o), .flush_addr_o(flush_addr_o),
    .bus_err_o(bus_err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input logic [63:0] nm, input string fld, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s %s got %h expected %h", nm, fld, act, expv);
    end
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare mid-cycle.
  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.name, "stall",   {26'd0, stall_o},   {26'd0, mon_e.stall});
      chk(mon_e.name, "flush",   {31'd0, flush_o},   {31'd0, mon_e.flush});
      chk(mon_e.name, "faddr",   flush_addr_o,       mon_e.addr);
      chk(mon_e.name, "bus_err", {31'd0, bus_err_o}, {31'd0, mon_e.bus_err});
      chk(mon_e.name, "cnt",     stall_cnt_o,        mon_e.cnt);
    end
  end

  task automatic clr();
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
    id_rs1_re_i = 1'b0; id_rs2_re_i = 1'b0; ex_inst_is_load_i = 1'b0;
    ex_mc_start_i = 1'b0; ex_mc_done_i = 1'b0;
    mem_req_i = 1'b0; mem_ack_i = 1'b0;
    jump_i = 1'b0; jump_addr_i = 32'h0000_0080;
  endtask

  task automatic step(input logic [63:0] nm, input logic [5:0] st, input logic fl,
                      input logic [31:0] ad, input logic be);
    exp_t e;
    e.name = nm; e.stall = st; e.flush = fl; e.addr = ad; e.bus_err = be; e.cnt = exp_cnt;
    exp_q.push_back(e);
    if (st != 6'b000000) exp_cnt++;
    @(posedge clk_i); #1;
  endtask

  initial begin
    clr();
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    // Stall sources present while held in reset must not leak out.
    mem_req_i = 1'b1; jump_i = 1'b1;
    step("rst", S0, 1'b0, 32'h0, 1'b0);
    clr();
    rst_i = 1'b1;
    step("idle", S0, 1'b0, 32'h0, 1'b0);

    // Load-use on rs2, then x0 target, then rs1 with and without read-enable.
    ex_inst_is_load_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_re_i = 1'b1;
    step("lu_rs2", SLU, 1'b0, 32'h0, 1'b0);
    clr();
    step("lu_gone", S0, 1'b0, 32'h0, 1'b0);
    ex_inst_is_load_i = 1'b1; ex_rd_i = 5'd0; id_rs2_i = 5'd0; id_rs2_re_i = 1'b1;
    step("lu_x0", S0, 1'b0, 32'h0, 1'b0);
    clr();
    ex_inst_is_load_i = 1'b1; ex_rd_i = 5'd9; id_rs1_i = 5'd9; id_rs1_re_i = 1'b0;
    step("lu_nore", S0, 1'b0, 32'h0, 1'b0);
    id_rs1_re_i = 1'b1;
    step("lu_rs1", SLU, 1'b0, 32'h0, 1'b0);
    clr();

    // Multi-cycle: start + 31 busy cycles stalled, released on done.
    ex_mc_start_i = 1'b1;
    step("mc_st", SMC, 1'b0, 32'h0, 1'b0);
    clr();
    repeat (31) step("mc_busy", SMC, 1'b0, 32'h0, 1'b0);
    ex_mc_done_i = 1'b1;
    step("mc_done", S0, 1'b0, 32'h0, 1'b0);
    clr();

    // Bus wait with ack on the third cycle; then same-cycle ack.
    mem_req_i = 1'b1;
    step("bw1", SMEM, 1'b0, 32'h0, 1'b0);
    step("bw2", SMEM, 1'b0, 32'h0, 1'b0);
    mem_ack_i = 1'b1;
    step("bw_ack", S0, 1'b0, 32'h0, 1'b0);
    step("bw_fast", S0, 1'b0, 32'h0, 1'b0);
    clr();

    // Bus timeout: 16 stalled cycles, single error pulse, then idle.
    mem_req_i = 1'b1;
    repeat (16) step("to_wait", SMEM, 1'b0, 32'h0, 1'b0);
    clr();
    step("to_err", S0, 1'b0, 32'h0, 1'b1);
    step("to_idle", S0, 1'b0, 32'h0, 1'b0);

    // Jumps: taken in IDLE, held off during MC_BUSY, taken on release.
    jump_i = 1'b1;
    step("jmp_idle", S0, 1'b1, 32'h0000_0080, 1'b0);
    clr();
    ex_mc_start_i = 1'b1;
    step("jmc_st", SMC, 1'b0, 32'h0, 1'b0);
    clr();
    jump_i = 1'b1;
    step("jmc_busy", SMC, 1'b0, 32'h0, 1'b0);
    ex_mc_done_i = 1'b1; jump_addr_i = 32'h0000_1234;
    step("jmc_done", S0, 1'b1, 32'h0000_1234, 1'b0);
    clr();
    jump_i = 1'b1;
    ex_inst_is_load_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_re_i = 1'b1;
    step("jmp_lu", S0, 1'b1, 32'h0000_0080, 1'b0);
    clr();

    // Bus wait interrupting a multi-cycle op: resumes MC_BUSY after ack.
    ex_mc_start_i = 1'b1;
    step("nm_st", SMC, 1'b0, 32'h0, 1'b0);
    clr();
    mem_req_i = 1'b1;
    step("nm_mem", SMEM, 1'b0, 32'h0, 1'b0);
    step("nm_wait", SMEM, 1'b0, 32'h0, 1'b0);
    mem_ack_i = 1'b1;
    step("nm_ack", S0, 1'b0, 32'h0, 1'b0);
    clr();
    step("nm_back", SMC, 1'b0, 32'h0, 1'b0);
    ex_mc_done_i = 1'b1;
    step("nm_done", S0, 1'b0, 32'h0, 1'b0);
    clr();

    // Done captured during MEM_WAIT: MC_BUSY is skipped on return.
    ex_mc_start_i = 1'b1;
    step("nd_st", SMC, 1'b0, 32'h0, 1'b0);
    clr();
    mem_req_i = 1'b1;
    step("nd_mem", SMEM, 1'b0, 32'h0, 1'b0);
    ex_mc_done_i = 1'b1;
    step("nd_done", SMEM, 1'b0, 32'h0, 1'b0);
    ex_mc_done_i = 1'b0; mem_ack_i = 1'b1;
    step("nd_ack", S0, 1'b0, 32'h0, 1'b0);
    clr();
    step("nd_idle", S0, 1'b0, 32'h0, 1'b0);

    // Async reset mid-MEM_WAIT clears everything at once; counter restarts.
    mem_req_i = 1'b1;
    step("rm_w1", SMEM, 1'b0, 32'h0, 1'b0);
    step("rm_w2", SMEM, 1'b0, 32'h0, 1'b0);
    rst_i = 1'b0;
    exp_cnt = 0;
    step("rm_rst", S0, 1'b0, 32'h0, 1'b0);
    clr();
    rst_i = 1'b1;
    step("rm_rel", S0, 1'b0, 32'h0, 1'b0);
    ex_inst_is_load_i = 1'b1; ex_rd_i = 5'd3; id_rs1_i = 5'd3; id_rs1_re_i = 1'b1;
    step("rm_lu", SLU, 1'b0, 32'h0, 1'b0);
    clr();
    step("rm_cnt", S0, 1'b0, 32'h0, 1'b0);

    repeat (2) @(posedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
